// File: rtl/alu_exec.sv
// Execute-stage ALU with a one-entry output buffer and valid/ready handshakes on both sides.
// Define SERIAL_SHIFT_EN to run SLL/SRL/SRA as a 1-bit-per-cycle engine instead of a barrel shifter.
module alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cmp,
    output logic            illegal,
    output logic [1:0]      o_dbg_state
);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and flush forces in_ready low for its whole cycle.

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_EQ   = 4'b1001;
    localparam logic [3:0] ALU_NEQ  = 4'b1010;
    localparam logic [3:0] ALU_GE   = 4'b1011;
    localparam logic [3:0] ALU_GEU  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_result;
    logic              r_cmp;
    logic              r_illegal;

    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_calc_result;
    logic              w_calc_cmp;
    logic              w_calc_illegal;
    logic              w_is_cmp;
    logic              w_serial_start;
    logic              w_shift_last;
    logic              w_accept;

    assign w_shamt = op_b[SHW-1:0];

`ifdef SERIAL_SHIFT_EN
    logic [SHW-1:0]    r_shcnt;
    logic [3:0]        r_op;
    logic              w_is_shift;

    assign w_is_shift     = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
    assign w_serial_start = w_is_shift && (w_shamt != '0);
    assign w_shift_last   = (r_shcnt == SHW'(1));
`else
    assign w_serial_start = 1'b0;
    assign w_shift_last   = 1'b1;
`endif

    // Single-cycle datapath; serial shifts load op_a here and refine it in the SHIFT state.
    always_comb begin
        w_calc_result  = '0;
        w_calc_cmp     = 1'b0;
        w_calc_illegal = 1'b0;
        w_is_cmp       = 1'b0;
        case (alu_op)
            ALU_ADD:  w_calc_result = op_a + op_b;
            ALU_SUB:  w_calc_result = op_a - op_b;
            ALU_XOR:  w_calc_result = op_a ^ op_b;
            ALU_OR:   w_calc_result = op_a | op_b;
            ALU_AND:  w_calc_result = op_a & op_b;
`ifdef SERIAL_SHIFT_EN
            ALU_SLL, ALU_SRL, ALU_SRA: w_calc_result = op_a;
`else
            ALU_SLL:  w_calc_result = op_a << w_shamt;
            ALU_SRL:  w_calc_result = op_a >> w_shamt;
            ALU_SRA:  w_calc_result = $signed(op_a) >>> w_shamt;
`endif
            ALU_SLT:  begin w_is_cmp = 1'b1; w_calc_cmp = $signed(op_a) <  $signed(op_b); end
            ALU_SLTU: begin w_is_cmp = 1'b1; w_calc_cmp = op_a <  op_b;                   end
            ALU_EQ:   begin w_is_cmp = 1'b1; w_calc_cmp = op_a == op_b;                   end
            ALU_NEQ:  begin w_is_cmp = 1'b1; w_calc_cmp = op_a != op_b;                   end
            ALU_GE:   begin w_is_cmp = 1'b1; w_calc_cmp = $signed(op_a) >= $signed(op_b); end
            ALU_GEU:  begin w_is_cmp = 1'b1; w_calc_cmp = op_a >= op_b;                   end
            default:  w_calc_illegal = 1'b1;
        endcase
        if (w_is_cmp) begin
            w_calc_result = {{(XLEN-1){1'b0}}, w_calc_cmp};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = !flush && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
        w_accept    = in_valid && in_ready;
        out_valid   = (r_state == S_DONE);
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) w_state_nxt = w_serial_start ? S_SHIFT : S_DONE;
                end
                S_SHIFT: begin
                    if (w_shift_last) w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (w_accept)       w_state_nxt = w_serial_start ? S_SHIFT : S_DONE;
                    else if (out_ready) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_cmp     <= 1'b0;
            r_illegal <= 1'b0;
`ifdef SERIAL_SHIFT_EN
            r_shcnt   <= '0;
            r_op      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_result  <= w_calc_result;
                r_cmp     <= w_calc_cmp;
                r_illegal <= w_calc_illegal;
`ifdef SERIAL_SHIFT_EN
                r_shcnt   <= w_serial_start ? w_shamt : '0;
                r_op      <= alu_op;
`endif
            end
`ifdef SERIAL_SHIFT_EN
            else if (flush) begin
                r_shcnt <= '0;
            end else if ((r_state == S_SHIFT) && (r_shcnt != '0)) begin
                r_shcnt <= r_shcnt - SHW'(1);
                case (r_op)
                    ALU_SLL: r_result <= {r_result[XLEN-2:0], 1'b0};
                    ALU_SRL: r_result <= {1'b0, r_result[XLEN-1:1]};
                    default: r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
                endcase
            end
`endif
        end
    end

    assign result      = r_result;
    assign cmp         = r_cmp;
    assign illegal     = r_illegal;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a queue-based model checks every cycle, literal expectations pin the model.
module tb_alu_exec;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, cmp, illegal;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op_a, op_b, result;
    logic [1:0]      o_dbg_state;

    alu_exec #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cmp(cmp), .illegal(illegal), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    // Packed as {illegal, cmp, result}.
    function automatic logic [XLEN+1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic c, ill, is_cmp;
        r = '0; c = 1'b0; ill = 1'b0; is_cmp = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a << b[4:0];
            4'd2:  begin is_cmp = 1; c = ($signed(a) < $signed(b)); end
            4'd3:  begin is_cmp = 1; c = (a < b); end
            4'd4:  r = a ^ b;
            4'd5:  r = a >> b[4:0];
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = a - b;
            4'd9:  begin is_cmp = 1; c = (a == b); end
            4'd10: begin is_cmp = 1; c = (a != b); end
            4'd11: begin is_cmp = 1; c = ($signed(a) >= $signed(b)); end
            4'd12: begin is_cmp = 1; c = (a >= b); end
            4'd13: r = $signed(a) >>> b[4:0];
            default: ill = 1'b1;
        endcase
        if (is_cmp) r = c ? 32'd1 : 32'd0;
        return {ill, c, r};
    endfunction

    // Cycles from the sampling point before the accepting edge to the first visible result.
    function automatic int latency(input logic [3:0] op, input logic [XLEN-1:0] b);
        int k;
        k = 0;
`ifdef SERIAL_SHIFT_EN
        if (op == 4'd1 || op == 4'd5 || op == 4'd13) k = int'(b[4:0]);
`endif
        return 1 + k;
    endfunction

    // ---------------- scoreboard ----------------
    logic [XLEN+1:0] exp_q[$];
    int              due_q[$];
    int              acc_q[$];
    logic [XLEN+1:0] ret_q[$];
    int              ret_lat_q[$];
    bit              new_front = 0;
    int              first_ov = 0;

    always @(negedge clk) begin
        bit              due_now, exp_ir;
        logic [1:0]      exp_state;
        logic [XLEN+1:0] e;
        if (!rst_n) begin
            exp_q.delete(); due_q.delete(); acc_q.delete(); new_front = 0;
        end
        due_now   = (exp_q.size() > 0) && (cyc >= due_q[0]);
        exp_state = (exp_q.size() == 0) ? 2'd0 : (due_now ? 2'd2 : 2'd1);
        exp_ir    = !flush && ((exp_q.size() == 0) || (due_now && out_ready));
        chk("out_valid", 32'(out_valid), 32'(due_now));
        chk("in_ready",  32'(in_ready),  32'(exp_ir));
        chk("state",     32'(o_dbg_state), 32'(exp_state));
        if (due_now) begin
            e = exp_q[0];
            chk("result",  result, e[XLEN-1:0]);
            chk("cmp",     32'(cmp), 32'(e[XLEN]));
            chk("illegal", 32'(illegal), 32'(e[XLEN+1]));
            if (new_front && out_valid) begin
                first_ov  = cyc;
                new_front = 0;
            end
            if (out_ready && !flush) begin
                ret_q.push_back({illegal, cmp, result});
                ret_lat_q.push_back(first_ov - acc_q[0]);
                void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(acc_q.pop_front());
                new_front = 1;
            end
        end
        if (flush) begin
            exp_q.delete(); due_q.delete(); acc_q.delete(); new_front = 0;
        end
        if (rst_n && in_valid && exp_ir) begin
            exp_q.push_back(model(alu_op, op_a, op_b));
            due_q.push_back(cyc + latency(alu_op, op_b));
            acc_q.push_back(cyc);
            new_front = 1;
        end
    end

    // ---------------- driver tasks ----------------
    // Presents an op (leaving in_valid high) and returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n;
        in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drop();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_ret(input string name, input logic [XLEN-1:0] r, input logic c,
                             input logic ill, input int lat);
        logic [XLEN+1:0] g;
        int gl;
        if (ret_q.size() == 0) begin
            chk({name, "_missing"}, 32'(ret_q.size()), 32'd1);
            return;
        end
        g  = ret_q.pop_front();
        gl = ret_lat_q.pop_front();
        chk({name, "_res"}, g[XLEN-1:0], r);
        chk({name, "_cmp"}, 32'(g[XLEN]), 32'(c));
        chk({name, "_ill"}, 32'(g[XLEN+1]), 32'(ill));
        if (lat > 0) chk({name, "_lat"}, 32'(gl), 32'(lat));
    endtask

    // ---------------- directed vectors ----------------
    logic [3:0]      t_op [8] = '{4'd2, 4'd11, 4'd12, 4'd10, 4'd7, 4'd5, 4'd1, 4'd6};
    logic [XLEN-1:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                                  32'hF0F0F0F0, 32'h80000000, 32'h12345678, 32'h000000F0};
    logic [XLEN-1:0] t_b  [8] = '{32'd1, 32'd1, 32'd1, 32'd5,
                                  32'hFF00FF00, 32'h0000001F, 32'h00000020, 32'h0000000F};
    logic [XLEN-1:0] t_r  [8] = '{32'd1, 32'd0, 32'd1, 32'd0,
                                  32'hF000F000, 32'd1, 32'h12345678, 32'h000000FF};
    logic            t_c  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    int sra_lat;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; op_a = '0; op_b = '0;
`ifdef SERIAL_SHIFT_EN
        sra_lat = 5;
`else
        sra_lat = 1;
`endif
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cmp", 32'(cmp), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Wrapping add
        out_ready = 1'b1;
        send(4'd0, 32'h7FFFFFFF, 32'd1); drop(); wait_idle();
        check_ret("add", 32'h80000000, 1'b0, 1'b0, 1);

        // Back-to-back single-cycle ops
        send(4'd8, 32'd5, 32'd7);
        send(4'd3, 32'd1, 32'hFFFFFFFF);
        send(4'd9, 32'd3, 32'd3);
        drop(); wait_idle();
        check_ret("sub", 32'hFFFFFFFE, 1'b0, 1'b0, 1);
        check_ret("sltu", 32'd1, 1'b1, 1'b0, 1);
        check_ret("eq", 32'd1, 1'b1, 1'b0, 1);

        // Arithmetic right shift, upper op_b bits ignored
        send(4'd13, 32'h80000000, 32'h00000024); drop(); wait_idle();
        check_ret("sra", 32'hF8000000, 1'b0, 1'b0, sra_lat);

        // Mixed table incl. signed/unsigned compares and shamt 0
        for (int i = 0; i < 8; i++) send(t_op[i], t_a[i], t_b[i]);
        drop(); wait_idle();
        for (int i = 0; i < 8; i++) check_ret($sformatf("tbl%0d", i), t_r[i], t_c[i], 1'b0, 0);

        // Backpressure, then retire and accept on the same edge
        out_ready = 1'b0;
        send(4'd4, 32'hA5A5A5A5, 32'h0F0F0F0F); drop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_result", result, 32'hAAAAAAAA);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd6, 32'h000000F0, 32'h0000000F); drop(); wait_idle();
        check_ret("xor", 32'hAAAAAAAA, 1'b0, 1'b0, 0);
        check_ret("or", 32'h000000FF, 1'b0, 1'b0, 1);

        // Illegal opcode
        send(4'hF, 32'd1, 32'd2); drop(); wait_idle();
        check_ret("illegal", 32'd0, 1'b0, 1'b1, 1);

        // Flush kills the in-flight/buffered SLL and refuses the op offered alongside it
        out_ready = 1'b0;
        send(4'd1, 32'd1, 32'd31); drop();
        repeat (3) @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; alu_op = 4'd0; op_a = 32'd2; op_b = 32'd3;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_state", 32'(o_dbg_state), 32'd0);
        chk("post_flush_ready", 32'(in_ready), 32'd1);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd0, 32'd2, 32'd3); drop(); wait_idle();
        check_ret("after_flush", 32'd5, 1'b0, 1'b0, 1);

        // Asynchronous reset in the middle of an operation
        out_ready = 1'b0;
        send(4'd5, 32'hF0000000, 32'd8); drop();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'd0, 32'h10, 32'h20); drop(); wait_idle();
        check_ret("after_rst", 32'h30, 1'b0, 1'b0, 1);
        chk("no_stray_results", 32'(ret_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
